jp_responder: RTL
=================

// Module: jp_responder
// PURPOSE
//  Emulates a standard NES controller: the serial responder at the far end of the rp2a03 joypad port.
//  Samples the jp_latch/jp_clk strobes driven by rp2a03 and returns button state on the active-low data line.
//  One instance per port; its output drives NES_JOYPAD_DATA1 or NES_JOYPAD_DATA2 in nes_top, which currently ties both high.
//  Button state arrives as a parallel 8-bit vector from a host/USB/keyboard front-end.
// PARAMETERS
//  SYNC_STAGES     2   flops on jp_latch_in/jp_clk_in before edge detection (0 = strobes already in clk_in domain)
//  BLOCK_OPPOSING  1   1 = on parallel load, mask Up+Down and Left+Right pairs pressed together to "neither"
// PORTS
//  clk_in          in   1  system clock (100 MHz domain)
//  rst_in          in   1  synchronous reset, active-high
//  buttons_in      in   8  active-high pressed: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//  jp_latch_in     in   1  latch strobe from rp2a03 (jp_latch)
//  jp_clk_in       in   1  shift clock from rp2a03 (jp_clk)
//  jp_data_out     out  1  serial data to rp2a03 jp_dataN_in, active-low (0 = pressed)
//  bit_idx_out     out  4  index of bit currently presented, 0..8 (8 = exhausted)
//  poll_done_out   out  1  one-cycle pulse when the 8th shift completes
// BEHAVIOUR
//  Reset: shift reg = 8'h00, bit_idx = 0, state LOAD_WAIT, jp_data_out = 1, poll_done_out = 0, sync flops = 0.
//  Strobes pass through SYNC_STAGES flops; latch_s/clk_s are synced levels; clk_rise = clk_s & ~clk_s_d.
//  Load value ld = buttons_in; if BLOCK_OPPOSING: ld[5:4]==2'b11 -> 2'b00, ld[7:6]==2'b11 -> 2'b00.
//  States:
//   LATCHED  : latch_s==1. Shift reg <= ld every cycle (transparent, live buttons); bit_idx <= 0;
//              clk_rise ignored. latch_s falls -> SHIFT (shift reg keeps last loaded value).
//   SHIFT    : present shreg[0]. On clk_rise: shreg <= {1'b1, shreg[7:1]}, bit_idx++;
//              bit_idx 7->8 -> DONE, poll_done_out pulses that same cycle.
//   DONE     : present "pressed" (jp_data_out=0) forever, matching official pads reading 1 after 8 bits;
//              further clk_rise ignored, bit_idx holds 8.
//   LOAD_WAIT: post-reset state; presents jp_data_out=1 (nothing pressed) until first latch_s=1.
//  Any state: latch_s==1 -> LATCHED next cycle (latch has priority over a same-cycle clk_rise).
//  jp_data_out = ~shreg[0] in LATCHED/SHIFT; registered, 1 cycle after state/shreg update.
//  Latency jp_clk_in edge -> new jp_data_out: SYNC_STAGES + 2 clk_in cycles; rp2a03 reads >=1 CPU cycle later,
//   so at 100 MHz no read sees a stale bit for SYNC_STAGES<=4.
//  buttons_in changes during SHIFT/DONE do not affect the current poll.
//  Reset mid-poll: returns to LOAD_WAIT immediately, outputs to reset values on the next edge.
//  poll_done_out never asserts in LATCHED or LOAD_WAIT; bit_idx_out is the registered counter.
// TESTING
//  1 buttons_in=8'h09 (A,Start), latch pulse, 8 clk rises -> jp_data_out sequence 0,1,1,0,1,1,1,1; poll_done 1 pulse.
//  2 continue with 4 extra clk rises after test 1 -> jp_data_out stays 0, bit_idx_out stays 8, no poll_done.
//  3 BLOCK_OPPOSING=1, buttons_in=8'h30 (Up+Down) -> bits 4,5 read as 1 (released); with =0 they read 0.
//  4 latch high, toggle buttons_in 8'h01->8'h00 -> jp_data_out follows 0->1 within SYNC_STAGES+2 cycles.
//  5 latch rises on same cycle as clk_rise mid-poll (bit_idx=3) -> state LATCHED, bit_idx 0, no shift seen.
//  6 rst_in asserted at bit_idx=5 -> next cycle jp_data_out=1, bit_idx=0, LOAD_WAIT; next poll fully correct.

Source files
------------

// File: rtl/jp_responder.sv
// -----------------------------------------------------------------------------
// jp_responder
//   Emulates a standard NES controller: the serial responder at the far end of
//   the rp2a03 joypad port. The jp_latch/jp_clk strobes are synchronised into
//   the clk_in domain. Button state is then returned one bit per shift clock on
//   an active-low data line, in the order A, B, Select, Start, Up, Down, Left,
//   Right. After the eighth bit the line reads "pressed" (0), as official pads
//   do.
//
// Parameters
//   SYNC_STAGES     flops on each strobe before edge detection (0 = already
//                   in the clk_in domain)
//   BLOCK_OPPOSING  1 = Up+Down and Left+Right pressed together load as
//                   "neither pressed"
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous reset, active-high
//   buttons_in[7:0] active-high pressed: A,B,Select,Start,Up,Down,Left,Right
//   jp_latch_in     latch strobe from rp2a03
//   jp_clk_in       shift clock from rp2a03
//   jp_data_out     serial data to rp2a03, active-low (0 = pressed)
//   bit_idx_out     index of the bit currently presented, 0..8 (8 = exhausted)
//   poll_done_out   one-cycle pulse when the eighth shift completes
// -----------------------------------------------------------------------------
module jp_responder #(
   parameter int SYNC_STAGES    = 2,
   parameter bit BLOCK_OPPOSING = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] buttons_in,
   input  logic       jp_latch_in,
   input  logic       jp_clk_in,
   output logic       jp_data_out,
   output logic [3:0] bit_idx_out,
   output logic       poll_done_out
);

   typedef enum logic [1:0] {
      LOAD_WAIT = 2'd0,
      LATCHED   = 2'd1,
      SHIFT     = 2'd2,
      DONE      = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [3:0]  bit_idx_q, bit_idx_d;
   logic        poll_done_q, poll_done_d;
   logic        data_q, data_d;
   logic        clk_s_q;
   logic        latch_s, clk_s, clk_rise;
   logic [7:0]  ld;

   // ---------------------------------------------------------------------------
   // Strobe synchronisers
   // ---------------------------------------------------------------------------
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign latch_s = jp_latch_in;
         assign clk_s   = jp_clk_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] latch_sync_q;
         logic [SYNC_STAGES-1:0] clk_sync_q;

         // NOTE: clocked state uses non-blocking assignments so every flop
         // samples the pre-edge value of its neighbour; a blocking chain here
         // would collapse the synchroniser into a single stage.
         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               latch_sync_q <= '0;
               clk_sync_q   <= '0;
            end else begin
               latch_sync_q[0] <= jp_latch_in;
               clk_sync_q[0]   <= jp_clk_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  latch_sync_q[i] <= latch_sync_q[i-1];
                  clk_sync_q[i]   <= clk_sync_q[i-1];
               end
            end
         end

         assign latch_s = latch_sync_q[SYNC_STAGES-1];
         assign clk_s   = clk_sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign clk_rise = clk_s & ~clk_s_q;

   // ---------------------------------------------------------------------------
   // Parallel load value, with simultaneous opposing directions cancelled
   // ---------------------------------------------------------------------------
   always_comb begin
      ld = buttons_in;
      if (BLOCK_OPPOSING) begin
         if (buttons_in[5:4] == 2'b11) ld[5:4] = 2'b00;
         if (buttons_in[7:6] == 2'b11) ld[7:6] = 2'b00;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_idx_d   = bit_idx_q;
      poll_done_d = 1'b0;

      if (latch_s) begin
         // Latch wins over a same-cycle shift clock from any state; the
         // register stays transparent to live buttons while latch is held.
         state_d   = LATCHED;
         shreg_d   = ld;
         bit_idx_d = 4'd0;
      end else begin
         unique case (state_q)
            LATCHED: state_d = SHIFT;
            SHIFT: begin
               if (clk_rise) begin
                  // Ones shift in from the top so the line reads "pressed"
                  // past the end, matching DONE.
                  shreg_d   = {1'b1, shreg_q[7:1]};
                  bit_idx_d = bit_idx_q + 4'd1;
                  if (bit_idx_q == 4'd7) begin
                     state_d     = DONE;
                     poll_done_d = 1'b1;
                  end
               end
            end
            LOAD_WAIT, DONE: ;
            default: state_d = LOAD_WAIT;
         endcase
      end
   end

   // Output bit follows the current state/shreg one cycle later.
   always_comb begin
      data_d = 1'b1;
      unique case (state_q)
         LATCHED, SHIFT: data_d = ~shreg_q[0];
         DONE:           data_d = 1'b0;
         default:        data_d = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= LOAD_WAIT;
         shreg_q     <= 8'h00;
         bit_idx_q   <= 4'd0;
         poll_done_q <= 1'b0;
         data_q      <= 1'b1;
         clk_s_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_idx_q   <= bit_idx_d;
         poll_done_q <= poll_done_d;
         data_q      <= data_d;
         clk_s_q     <= clk_s;
      end
   end

   assign jp_data_out   = data_q;
   assign bit_idx_out   = bit_idx_q;
   assign poll_done_out = poll_done_q;

endmodule
